// File: rtl/uart_tx.sv
// uart_tx: 8N1 serial transmitter with a memory-mapped style interface.
// A byte written with `load` is sent LSB first at CLKS_PER_BIT clocks per bit.
// `out[15]` reports busy; all other status bits read as zero.
// Optional feature: define UART_TX_PARITY_EN to add an even-parity bit
// between the last data bit and the stop bit (8E1 framing).
module uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 217
) (
  input  logic        clk,
  input  logic        clear,
  input  logic        load,
  input  logic [15:0] in,
  output logic        TX,
  output logic [15:0] out
);

  // Last baud count of a bit period; the counter wraps here and never overflows.
  localparam logic [15:0] BaudLast = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
`ifdef UART_TX_PARITY_EN
    StParity,
`endif
    StStop
  } state_e;

  state_e      state_q;
  logic [15:0] baud_q;
  logic [3:0]  bit_q;
  logic [7:0]  shift_q;
  logic        tx_q;
  logic        busy_q;
`ifdef UART_TX_PARITY_EN
  logic        parity_q;
`endif

  // Only the low byte of the write data is transmitted.
  logic [7:0] unused_in_hi;
  assign unused_in_hi = in[15:8];

  logic baud_wrap;
  assign baud_wrap = (baud_q == BaudLast);

  // Frame sequencer; TX and busy are registered so the line changes only on bit boundaries.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state_q  <= StIdle;
      baud_q   <= 16'd0;
      bit_q    <= 4'd0;
      shift_q  <= 8'hFF;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        StIdle: begin
          tx_q   <= 1'b1;
          busy_q <= 1'b0;
          if (load) begin
            shift_q  <= in[7:0];
`ifdef UART_TX_PARITY_EN
            parity_q <= ^in[7:0];
`endif
            busy_q   <= 1'b1;
            baud_q   <= 16'd0;
            tx_q     <= 1'b0;  // start bit begins on the load edge
            state_q  <= StStart;
          end
        end

        StStart: begin
          if (baud_wrap) begin
            baud_q  <= 16'd0;
            bit_q   <= 4'd0;
            tx_q    <= shift_q[0];
            state_q <= StData;
          end else begin
            baud_q <= baud_q + 16'd1;
          end
        end

        StData: begin
          if (baud_wrap) begin
            baud_q  <= 16'd0;
            shift_q <= {1'b0, shift_q[7:1]};
            bit_q   <= bit_q + 4'd1;
            if (bit_q == 4'd7) begin
`ifdef UART_TX_PARITY_EN
              tx_q    <= parity_q;
              state_q <= StParity;
`else
              tx_q    <= 1'b1;
              state_q <= StStop;
`endif
            end else begin
              tx_q <= shift_q[1];  // next LSB after this shift
            end
          end else begin
            baud_q <= baud_q + 16'd1;
          end
        end

`ifdef UART_TX_PARITY_EN
        StParity: begin
          if (baud_wrap) begin
            baud_q  <= 16'd0;
            tx_q    <= 1'b1;
            state_q <= StStop;
          end else begin
            baud_q <= baud_q + 16'd1;
          end
        end
`endif

        StStop: begin
          if (baud_wrap) begin
            baud_q  <= 16'd0;
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end else begin
            baud_q <= baud_q + 16'd1;
          end
        end

        default: begin
          state_q <= StIdle;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
          baud_q  <= 16'd0;
        end
      endcase
    end
  end

  assign TX  = tx_q;
  assign out = {busy_q, 15'd0};

endmodule
